dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for a single-issue core: word RAM plus four MMIO registers
// (CYCLE, OUTREG, WRCOUNT, STATUS) with combinational loads and edge-committed stores.
module dmem_responder #(
    parameter int RAM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] outreg,
    output logic        err
);

    localparam int          AW           = $clog2(RAM_WORDS);
    localparam logic [31:0] CYCLE_ADDR   = 32'hFFFF_FFF0;
    localparam logic [31:0] OUTREG_ADDR  = 32'hFFFF_FFF4;
    localparam logic [31:0] WRCOUNT_ADDR = 32'hFFFF_FFF8;
    localparam logic [31:0] STATUS_ADDR  = 32'hFFFF_FFFC;

    logic [31:0] ram_r [RAM_WORDS];
    logic [31:0] cycle_r;
    logic [31:0] outreg_r;
    logic [15:0] wrcount_r;
    logic [1:0]  status_r;
    logic [1:0]  status_next_s;

    logic          aligned_s;
    logic          ram_hit_s;
    logic          mmio_hit_s;
    logic [AW-1:0] idx_s;
    logic          wr_ok_s;
    logic          wr_misalign_s;
    logic          wr_unmapped_s;
    logic          ram_we_s;
    logic          out_we_s;
    logic          wrc_we_s;
    logic          stat_we_s;

    assign aligned_s  = (addr[1:0] == 2'b00);
    assign ram_hit_s  = (addr[31:AW+2] == {(30-AW){1'b0}});
    assign idx_s      = addr[AW+1:2];
    assign mmio_hit_s = (addr == CYCLE_ADDR) || (addr == OUTREG_ADDR) ||
                        (addr == WRCOUNT_ADDR) || (addr == STATUS_ADDR);

    // Alignment is judged before the map, so a misaligned unmapped store only flags MISALIGN.
    assign wr_misalign_s = memwrite & ~aligned_s;
    assign wr_ok_s       = memwrite & aligned_s;
    assign wr_unmapped_s = wr_ok_s & ~ram_hit_s & ~mmio_hit_s;
    assign ram_we_s      = wr_ok_s & ram_hit_s;
    assign out_we_s      = wr_ok_s & (addr == OUTREG_ADDR);
    assign wrc_we_s      = wr_ok_s & (addr == WRCOUNT_ADDR);
    assign stat_we_s     = wr_ok_s & (addr == STATUS_ADDR);

    // Load path: same-cycle read of pre-edge state, zero for misaligned or unmapped.
    always_comb begin
        readdata = 32'h0000_0000;
        if (!aligned_s) begin
            readdata = 32'h0000_0000;
        end else if (ram_hit_s) begin
            readdata = ram_r[idx_s];
        end else begin
            case (addr)
                CYCLE_ADDR:   readdata = cycle_r;
                OUTREG_ADDR:  readdata = outreg_r;
                WRCOUNT_ADDR: readdata = {16'h0000, wrcount_r};
                STATUS_ADDR:  readdata = {30'h0000_0000, status_r};
                default:      readdata = 32'h0000_0000;
            endcase
        end
    end

    // STATUS next value: write-1-to-clear on a STATUS store, otherwise sticky set by bad stores.
    always_comb begin
        status_next_s = status_r;
        if (stat_we_s) begin
            status_next_s = status_r & ~writedata[1:0];
        end else begin
            status_next_s = status_r | {wr_unmapped_s, wr_misalign_s};
        end
    end

    // RAM array, cleared asynchronously so a reset aborts any store on that edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram_r[i] <= 32'h0000_0000;
            end
        end else if (ram_we_s) begin
            ram_r[idx_s] <= writedata;
        end
    end

    // Free-running cycle counter; stores to it are silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // OUTREG load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outreg_r <= 32'h0000_0000;
        end else if (out_we_s) begin
            outreg_r <= writedata;
        end
    end

    // Saturating RAM-store counter with a bit-31 clear command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrcount_r <= 16'h0000;
        end else if (ram_we_s && (wrcount_r != 16'hFFFF)) begin
            wrcount_r <= wrcount_r + 16'd1;
        end else if (wrc_we_s && writedata[31]) begin
            wrcount_r <= 16'h0000;
        end
    end

    // Sticky STATUS flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_r <= 2'b00;
        end else begin
            status_r <= status_next_s;
        end
    end

    assign outreg = outreg_r;
    assign err    = status_r[0] | status_r[1];

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: expected load values go through a scoreboard queue
// and every comparison is an immediate assertion that counts failures.
module tb_dmem_responder;

    localparam logic [31:0] CYC = 32'hFFFF_FFF0;
    localparam logic [31:0] OUT = 32'hFFFF_FFF4;
    localparam logic [31:0] WRC = 32'hFFFF_FFF8;
    localparam logic [31:0] STA = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] outreg;
    logic        err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ram_m [64];

    dmem_responder #(.RAM_WORDS(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .outreg    (outreg),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Load: expected value queued when the address is driven, popped once readdata settles.
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] expv);
        memwrite = 1'b0;
        addr     = a;
        exp_q.push_back(expv);
        #1;
        check(tag, readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0;
        for (int i = 0; i < 64; i++) ram_m[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outreg", outreg, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        rd("reset_cycle", CYC, 32'h0);
        rd("reset_ram10", 32'h10, 32'h0);

        // Counter start values after release
        @(negedge clk);
        reset = 1'b0;
        rd("cycle_first", CYC, 32'd0);
        @(posedge clk); #1;
        rd("cycle_second", CYC, 32'd1);
        repeat (9) @(posedge clk);
        #1;
        rd("cycle_ten", CYC, 32'd10);
        wr(CYC, 32'h0);
        rd("cycle_wr_ignored", CYC, 32'd11);
        check("cycle_wr_no_err", {31'h0, err}, 32'h0);

        // RAM store then load
        wr(32'h10, 32'hDEAD_BEEF);
        ram_m[4] = 32'hDEAD_BEEF;
        rd("ram_load", 32'h10, 32'hDEAD_BEEF);
        rd("wrcount_one", WRC, 32'd1);
        rd("ram_neighbour", 32'h14, 32'h0);

        // Read during write returns old data
        memwrite = 1'b1; addr = 32'h20; writedata = 32'h1234_5678;
        #1;
        check("rdw_old", readdata, 32'h0);
        @(posedge clk); #1;
        memwrite = 1'b0;
        ram_m[8] = 32'h1234_5678;
        rd("rdw_new", 32'h20, 32'h1234_5678);

        // Misaligned / unmapped loads return zero and set no flag
        rd("ld_misaligned", 32'h11, 32'h0);
        rd("ld_unmapped", 32'h1000, 32'h0);
        rd("ld_no_flag", STA, 32'h0);

        // Misaligned and unmapped stores
        wr(32'h12, 32'hAAAA_AAAA);
        rd("misalign_ram", 32'h10, 32'hDEAD_BEEF);
        rd("misalign_status", STA, 32'h1);
        check("misalign_err", {31'h0, err}, 32'h1);
        wr(32'h1000, 32'h5555_5555);
        rd("unmapped_status", STA, 32'h3);
        rd("discard_wrcount", WRC, 32'd2);
        wr(STA, 32'h1);
        rd("w1c_bit0", STA, 32'h2);
        check("w1c_bit0_err", {31'h0, err}, 32'h1);
        wr(STA, 32'h2);
        rd("w1c_bit1", STA, 32'h0);
        check("w1c_bit1_err", {31'h0, err}, 32'h0);

        // OUTREG
        wr(OUT, 32'h0000_00A5);
        check("outreg_port", outreg, 32'h0000_00A5);
        rd("outreg_read", OUT, 32'h0000_00A5);

        // WRCOUNT saturation and clear (2 stores already counted)
        for (int i = 0; i < 65540; i++) begin
            wr(32'((i % 64) * 4), 32'(i * 3 + 1));
            ram_m[i % 64] = 32'(i * 3 + 1);
        end
        rd("wrcount_sat", WRC, 32'h0000_FFFF);
        rd("ram_after_loop10", 32'h10, ram_m[4]);
        rd("ram_after_loop20", 32'h20, ram_m[8]);
        wr(WRC, 32'h7FFF_FFFF);
        rd("wrcount_no_clear", WRC, 32'h0000_FFFF);
        wr(WRC, 32'h8000_0000);
        rd("wrcount_clear", WRC, 32'h0);

        // CYCLE wrap
        @(negedge clk);
        force dut.cycle_r = 32'hFFFF_FFFF;
        rd("cycle_forced", CYC, 32'hFFFF_FFFF);
        release dut.cycle_r;
        @(posedge clk); #1;
        rd("cycle_wrap", CYC, 32'h0);

        // Reset mid-operation aborts the pending store
        wr(32'h10, 32'h0000_0055);
        wr(OUT, 32'h0000_0077);
        check("pre_reset_outreg", outreg, 32'h0000_0077);
        memwrite = 1'b1; addr = 32'h10; writedata = 32'h0000_0099;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_outreg", outreg, 32'h0);
        check("midreset_ram", readdata, 32'h0);
        @(posedge clk); #1;
        check("midreset_edge_ram", readdata, 32'h0);
        memwrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        rd("post_reset_ram", 32'h10, 32'h0);
        rd("post_reset_wrcount", WRC, 32'h0);
        rd("post_reset_cycle", CYC, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
